// File: rtl/lock_detect.sv
// lock_detect: windowed lock-quality monitor with debounced lock/loss and a saturating loss counter
module lock_detect #(
    parameter int R  = 14,
    parameter int CW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [R-1:0] signal_in,
    input  logic signed [R-1:0] lock_lo,
    input  logic signed [R-1:0] lock_hi,
    input  logic [CW-1:0]       acq_thr,
    input  logic [CW-1:0]       lose_thr,
    input  logic                enable,
    input  logic                clear,
    output logic                locked,
    output logic                out_of_lock,
    output logic                lock_lost,
    output logic [15:0]         unlock_count,
    output logic [1:0]          state
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, UNLOCKED} state_t;

    state_t              state_q, state_d;
    logic signed [R-1:0] s_q;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc, acq_eff, lose_eff;
    logic                in_win, qual;
    logic                locked_q, locked_d, ool_q, ool_d, lost_q, lost_d;
    logic [15:0]         ucnt_q, ucnt_d;

    // An inverted window (lo > hi) can never satisfy both bounds, so it never qualifies.
    assign in_win   = (s_q >= lock_lo) && (s_q <= lock_hi);
    assign acq_eff  = acq_thr | CW'(acq_thr == '0);
    assign lose_eff = lose_thr | CW'(lose_thr == '0);
    assign qual     = (state_q == LOCKED) ? ~in_win : in_win;
    assign cnt_inc  = qual ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) : '0;

    // Next-state: clear beats disable beats normal debounce transitions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        lost_d  = 1'b0;
        ucnt_d  = ucnt_q;
        if (clear) begin
            state_d = enable ? ACQUIRE : IDLE;
            cnt_d   = '0;
            ucnt_d  = '0;
        end else if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                end
                ACQUIRE, UNLOCKED: if (cnt_inc == acq_eff) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                end
                LOCKED: if (cnt_inc == lose_eff) begin
                    state_d = UNLOCKED;
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                    ucnt_d  = (&ucnt_q) ? ucnt_q : ucnt_q + 16'd1;
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = state_d == LOCKED;
        ool_d    = state_d == UNLOCKED;
    end

    // State, counters and registered status flags; the input sample register keeps loading through clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            ool_q    <= 1'b0;
            lost_q   <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= signal_in;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            ool_q    <= ool_d;
            lost_q   <= lost_d;
            ucnt_q   <= ucnt_d;
        end
    end

    assign locked       = locked_q;
    assign out_of_lock  = ool_q;
    assign lock_lost    = lost_q;
    assign unlock_count = ucnt_q;
    assign state        = state_q;
endmodule

// File: tb/tb_lock_detect.sv
// tb_lock_detect: directed scoreboard bench for lock_detect
module tb_lock_detect;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, enable, clear;
    logic signed [13:0] signal_in, lock_lo, lock_hi;
    logic [31:0]        acq_thr, lose_thr;
    logic               locked, out_of_lock, lock_lost;
    logic [15:0]        unlock_count;
    logic [1:0]         state;

    lock_detect dut (
        .clk(clk), .rst(rst), .signal_in(signal_in), .lock_lo(lock_lo), .lock_hi(lock_hi),
        .acq_thr(acq_thr), .lose_thr(lose_thr), .enable(enable), .clear(clear),
        .locked(locked), .out_of_lock(out_of_lock), .lock_lost(lock_lost),
        .unlock_count(unlock_count), .state(state)
    );

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic        lost;
        logic [15:0] uc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s got %0d expected %0d at %0t", nm, fld, act, exp, $time);
        end
    endtask

    // Expected outputs are pushed right after the edge that should produce them.
    task automatic tick(input string nm, input logic chk, input logic [1:0] st, input logic lost, input logic [15:0] uc);
        exp_t e;
        @(posedge clk);
        #1;
        if (chk) begin
            e.name = nm;
            e.st   = st;
            e.lost = lost;
            e.uc   = uc;
            q.push_back(e);
        end
    endtask

    task automatic run(input string nm, input int n, input logic [1:0] st, input logic [15:0] uc);
        repeat (n) tick(nm, 1'b1, st, 1'b0, uc);
    endtask

    // Monitor: every cycle the outputs are valid, so pop one expectation per falling edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "state", 16'(state), 16'(e.st));
            cmp(e.name, "locked", 16'(locked), 16'(e.st == 2'd2));
            cmp(e.name, "out_of_lock", 16'(out_of_lock), 16'(e.st == 2'd3));
            cmp(e.name, "lock_lost", 16'(lock_lost), 16'(e.lost));
            cmp(e.name, "unlock_count", unlock_count, e.uc);
        end
    end

    initial begin
        rst = 1; enable = 0; clear = 0; signal_in = 500;
        lock_lo = -100; lock_hi = 100; acq_thr = 10; lose_thr = 5;
        repeat (3) tick("rst", 1'b0, 0, 0, 0);
        rst = 0;
        run("idle", 20, 0, 0);
        enable = 1;
        tick("enable", 1'b1, 1, 0, 0);
        signal_in = 0;
        run("acquire", 10, 1, 0);
        tick("lock", 1'b1, 2, 0, 0);
        signal_in = 300;
        run("glitch4", 4, 2, 0);
        signal_in = 0;
        run("glitch_end", 2, 2, 0);
        signal_in = 300;
        run("lose_wait", 5, 2, 0);
        tick("loss", 1'b1, 3, 1, 1);
        tick("loss_after", 1'b1, 3, 0, 1);
        signal_in = 0;
        run("reacq", 10, 3, 1);
        tick("relock", 1'b1, 2, 0, 1);
        acq_thr = 3; signal_in = 100; clear = 1;
        tick("clr_hi", 1'b1, 1, 0, 0);
        clear = 0;
        run("edge_hi", 2, 1, 0);
        tick("lock_hi", 1'b1, 2, 0, 0);
        signal_in = -100; clear = 1;
        tick("clr_lo", 1'b1, 1, 0, 0);
        clear = 0;
        run("edge_lo", 2, 1, 0);
        tick("lock_lo", 1'b1, 2, 0, 0);
        signal_in = 101; clear = 1;
        tick("clr_101", 1'b1, 1, 0, 0);
        clear = 0;
        run("out_101", 6, 1, 0);
        lock_lo = 50; lock_hi = -50; signal_in = 0; clear = 1;
        tick("clr_inv", 1'b1, 1, 0, 0);
        clear = 0;
        run("inv_win", 6, 1, 0);
        lock_lo = -100; lock_hi = 100; acq_thr = 0; clear = 1;
        tick("clr_thr0", 1'b1, 1, 0, 0);
        clear = 0;
        tick("thr0_lock", 1'b1, 2, 0, 0);
        lose_thr = 1; signal_in = 300;
        tick("l1_wait", 1'b1, 2, 0, 0);
        tick("l1_loss", 1'b1, 3, 1, 1);
        signal_in = 0;
        tick("r1_wait", 1'b1, 3, 0, 1);
        tick("r1_lock", 1'b1, 2, 0, 1);
        enable = 0;
        run("disable", 2, 0, 1);
        enable = 1;
        tick("reenable", 1'b1, 1, 0, 1);
        tick("reen_lock", 1'b1, 2, 0, 1);
        signal_in = 300;
        tick("l2_wait", 1'b1, 2, 0, 1);
        tick("l2_loss", 1'b1, 3, 1, 2);
        clear = 1;
        tick("clr_unl", 1'b1, 1, 0, 0);
        clear = 0; signal_in = 0;
        tick("c_wait", 1'b1, 1, 0, 0);
        tick("c_lock", 1'b1, 2, 0, 0);
        @(negedge clk);
        #1 force dut.ucnt_q = 16'hFFFE;
        #1 release dut.ucnt_q;
        signal_in = 300;
        tick("pre_sat", 1'b1, 2, 0, 16'hFFFE);
        tick("sat_loss1", 1'b1, 3, 1, 16'hFFFF);
        signal_in = 0;
        tick("sat_wait", 1'b1, 3, 0, 16'hFFFF);
        tick("sat_relock", 1'b1, 2, 0, 16'hFFFF);
        signal_in = 300;
        tick("sat_pre2", 1'b1, 2, 0, 16'hFFFF);
        tick("sat_loss2", 1'b1, 3, 1, 16'hFFFF);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
